// File: rtl/digital_tube.sv
// rtl/digital_tube.sv - four-digit multiplexed seven-segment display driver
module digital_tube #(
    parameter int SCAN_CYCLES   = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [3:0] single_digit,
    input  logic [3:0] ten_digit,
    input  logic [3:0] hundred_digit,
    input  logic [3:0] kilo_digit,
    output logic [3:0] csn,
    output logic [6:0] abcdefg
);

    // A single-cycle dwell still needs a one-bit counter that simply stays at zero.
    localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       csn_q, csn_d;
    logic [6:0]       seg_q, seg_d;

    logic [3:0]       cur_digit;
    logic             cur_blank;
    logic             blank_kilo, blank_hundred, blank_ten;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Leading-zero blanking: a digit goes dark only if it and every higher digit are zero.
    always_comb begin
        blank_kilo    = (BLANK_LEADING != 0) && (kilo_digit == 4'd0);
        blank_hundred = blank_kilo && (hundred_digit == 4'd0);
        blank_ten     = blank_hundred && (ten_digit == 4'd0);
    end

    // Select the digit currently being scanned, sampled live every cycle.
    always_comb begin
        cur_digit = single_digit;
        cur_blank = 1'b0;
        case (idx_q)
            2'd0: begin cur_digit = single_digit;  cur_blank = 1'b0;          end
            2'd1: begin cur_digit = ten_digit;     cur_blank = blank_ten;     end
            2'd2: begin cur_digit = hundred_digit; cur_blank = blank_hundred; end
            default: begin cur_digit = kilo_digit; cur_blank = blank_kilo;   end
        endcase
    end

    // Next-state: advance dwell/index when enabled, otherwise park at the ones digit with outputs dark.
    always_comb begin
        cnt_d = '0;
        idx_d = 2'd0;
        csn_d = 4'b1111;
        seg_d = 7'b0000000;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q;
            end
            csn_d = ~(4'b0001 << idx_q);
            seg_d = cur_blank ? 7'b0000000 : decode(cur_digit);
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            csn_q <= 4'b1111;
            seg_q <= 7'b0000000;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            csn_q <= csn_d;
            seg_q <= seg_d;
        end
    end

    assign csn     = csn_q;
    assign abcdefg = seg_q;

endmodule

// File: tb/tb_digital_tube.sv
// tb/tb_digital_tube.sv - self-checking bench for digital_tube
module tb_digital_tube;

    localparam int SCAN = 4;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [3:0] single_digit, ten_digit, hundred_digit, kilo_digit;
    logic [3:0] csn_b, csn_nb;
    logic [6:0] seg_b, seg_nb;

    int n_checks;
    int n_fail;
    int pos;

    digital_tube #(.SCAN_CYCLES(SCAN), .BLANK_LEADING(1)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .single_digit(single_digit), .ten_digit(ten_digit),
        .hundred_digit(hundred_digit), .kilo_digit(kilo_digit),
        .csn(csn_b), .abcdefg(seg_b)
    );

    digital_tube #(.SCAN_CYCLES(SCAN), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rstn(rstn), .en(en),
        .single_digit(single_digit), .ten_digit(ten_digit),
        .hundred_digit(hundred_digit), .kilo_digit(kilo_digit),
        .csn(csn_nb), .abcdefg(seg_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      s, t, h, k;
        logic [3:0][6:0] eb;
        logic [3:0][6:0] enb;
    } vec_t;

    typedef struct {
        logic [3:0] csn;
        logic [6:0] sb;
        logic [6:0] snb;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:  return 7'b1111110;
            4'd1:  return 7'b0110000;
            4'd2:  return 7'b1101101;
            4'd3:  return 7'b1111001;
            4'd4:  return 7'b0110011;
            4'd5:  return 7'b1011011;
            4'd6:  return 7'b1011111;
            4'd7:  return 7'b1110000;
            4'd8:  return 7'b1111111;
            4'd9:  return 7'b1111011;
            4'd10: return 7'b1110111;
            4'd11: return 7'b0011111;
            4'd12: return 7'b1001110;
            4'd13: return 7'b0111101;
            4'd14: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [3:0] digit_at(input int slot);
        case (slot)
            0: return single_digit;
            1: return ten_digit;
            2: return hundred_digit;
            default: return kilo_digit;
        endcase
    endfunction

    // Slots above (3 - leading zero count) are dark when blanking is on.
    function automatic int lead_zeros();
        if (kilo_digit != 0) return 0;
        if (hundred_digit != 0) return 1;
        if (ten_digit != 0) return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Push expectation, let one rising edge happen, then pop and compare.
    task automatic step(input logic [3:0] e_csn, input logic [6:0] e_sb, input logic [6:0] e_snb,
                        input string name);
        exp_t e;
        exp_t got;
        e.csn = e_csn; e.sb = e_sb; e.snb = e_snb;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({name, " csn"},     {28'd0, csn_b},  {28'd0, got.csn});
        chk({name, " csn_nb"},  {28'd0, csn_nb}, {28'd0, got.csn});
        chk({name, " seg"},     {25'd0, seg_b},  {25'd0, got.sb});
        chk({name, " seg_nb"},  {25'd0, seg_nb}, {25'd0, got.snb});
        chk({name, " onehot"}, ($countones(~csn_b) <= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Model-driven enabled step: slot derived from enabled-cycle count since scan start.
    task automatic model_step(input string name);
        int slot;
        logic [6:0] sv;
        slot = (pos / SCAN) % 4;
        sv = seg_of(digit_at(slot));
        step(~(4'b0001 << slot), (slot > 3 - lead_zeros()) ? 7'b0 : sv, sv, name);
        pos++;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        pos = 0;
        rstn = 1'b1;
        en = 1'b1;
        single_digit = 4'd2; ten_digit = 4'd4; hundred_digit = 4'd5; kilo_digit = 4'd0;

        vecs[0] = '{4'd2, 4'd4, 4'd5, 4'd0,
                    {7'b0000000, 7'b1011011, 7'b0110011, 7'b1101101},
                    {7'b1111110, 7'b1011011, 7'b0110011, 7'b1101101}};
        vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd0,
                    {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110},
                    {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        vecs[2] = '{4'd8, 4'd0, 4'd0, 4'd1,
                    {7'b0110000, 7'b1111110, 7'b1111110, 7'b1111111},
                    {7'b0110000, 7'b1111110, 7'b1111110, 7'b1111111}};
        vecs[3] = '{4'd7, 4'd0, 4'd3, 4'd0,
                    {7'b0000000, 7'b1111001, 7'b1111110, 7'b1110000},
                    {7'b1111110, 7'b1111001, 7'b1111110, 7'b1110000}};
        vecs[4] = '{4'd15, 4'd10, 4'd0, 4'd0,
                    {7'b0000000, 7'b0000000, 7'b1110111, 7'b1000111},
                    {7'b1111110, 7'b1111110, 7'b1110111, 7'b1000111}};
        vecs[5] = '{4'd11, 4'd13, 4'd14, 4'd12,
                    {7'b1001110, 7'b1001111, 7'b0111101, 7'b0011111},
                    {7'b1001110, 7'b1001111, 7'b0111101, 7'b0011111}};

        // Reset asserted before any clock edge: outputs already clear.
        #1;
        chk("reset async csn", {28'd0, csn_b}, 32'hF);
        chk("reset async seg", {25'd0, seg_b}, 32'h0);
        for (int i = 0; i < 6; i++) step(4'b1111, 7'b0, 7'b0, "reset held en=1");
        rstn = 1'b0;

        // Table vectors: one disabled edge, then five full-digit dwells to cover the wrap.
        for (int v = 0; v < 6; v++) begin
            en = 1'b0;
            single_digit = vecs[v].s; ten_digit = vecs[v].t;
            hundred_digit = vecs[v].h; kilo_digit = vecs[v].k;
            step(4'b1111, 7'b0, 7'b0, "disabled");
            en = 1'b1;
            for (int c = 0; c < 5 * SCAN; c++) begin
                int slot;
                slot = (c / SCAN) % 4;
                step(~(4'b0001 << slot), vecs[v].eb[slot], vecs[v].enb[slot], $sformatf("vec%0d c%0d", v, c));
            end
        end

        // en dropped mid-scan (slot 1 of second lap), then re-raised.
        en = 1'b0;
        step(4'b1111, 7'b0, 7'b0, "en drop");
        step(4'b1111, 7'b0, 7'b0, "en low hold");
        en = 1'b1;
        pos = 0;
        model_step("en reraise");
        for (int c = 0; c < 9; c++) model_step("after reraise");

        // Asynchronous reset mid-cycle, mid-scan.
        #2;
        rstn = 1'b1;
        #1;
        chk("midscan reset csn", {28'd0, csn_b}, 32'hF);
        chk("midscan reset seg_nb", {25'd0, seg_nb}, 32'h0);
        step(4'b1111, 7'b0, 7'b0, "reset midscan held");
        step(4'b1111, 7'b0, 7'b0, "reset midscan held");
        rstn = 1'b0;
        pos = 0;
        for (int c = 0; c < 8; c++) model_step("after reset release");

        // Sweep each digit position over 0..15; inputs change mid-scan and must show live.
        for (int p = 0; p < 4; p++) begin
            for (int val = 0; val < 16; val++) begin
                single_digit = 4'd0; ten_digit = 4'd0; hundred_digit = 4'd0; kilo_digit = 4'd0;
                case (p)
                    0: single_digit = 4'(val);
                    1: ten_digit = 4'(val);
                    2: hundred_digit = 4'(val);
                    default: kilo_digit = 4'(val);
                endcase
                for (int c = 0; c < 4 * SCAN; c++) model_step($sformatf("sweep p%0d v%0d", p, val));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog keeps the run bounded even if a wait never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
